// File: rtl/mwc_pkg.sv
// Shared types for the memory-write checker: FSM state encoding and mode selectors.
package mwc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PASS,
        FAIL,
        TIMEOUT
    } mwc_state_e;

    localparam int MWC_ORDERED = 0;
    localparam int MWC_SPARSE  = 1;

endpackage

// File: rtl/mwc_exp_table.sv
// Expected (address, data) table: synchronous write, asynchronous read, no reset.
module mwc_exp_table #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_EXP = 4,
    parameter int IDX_W   = $clog2(NUM_EXP + 1)
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o
);
    localparam int               SEL_W = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
    localparam logic [IDX_W-1:0] DEPTH = IDX_W'(NUM_EXP);

    logic [ADDR_W-1:0] addrMem [NUM_EXP];
    logic [DATA_W-1:0] dataMem [NUM_EXP];

    always_ff @(posedge clk_i) begin
        if (wr_en_i && (wr_idx_i < DEPTH)) begin
            addrMem[wr_idx_i[SEL_W-1:0]] <= wr_addr_i;
            dataMem[wr_idx_i[SEL_W-1:0]] <= wr_data_i;
        end
    end

    // Out-of-range indices read as zero so the index never leaves the array.
    always_comb begin
        rd_addr_o = '0;
        rd_data_o = '0;
        if (rd_idx_i < DEPTH) begin
            rd_addr_o = addrMem[rd_idx_i[SEL_W-1:0]];
            rd_data_o = dataMem[rd_idx_i[SEL_W-1:0]];
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// Snoops the core's data-memory write port and checks stores against a loadable table.
// Define CHECKER_DEBUG_EN to expose the offending write and table index captured on failure.
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_EXP     = 4,
    parameter int IDX_W       = $clog2(NUM_EXP + 1),
    parameter int TIMEOUT_CYC = 4000,
    parameter int SPARSE      = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exp_we,
    input  logic [IDX_W-1:0]  exp_idx,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              start,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [IDX_W-1:0]  match_cnt
`ifdef CHECKER_DEBUG_EN
    ,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [IDX_W-1:0]  fail_idx
`endif
);
    localparam int               CNT_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CYC_MAX   = '1;
    localparam logic [IDX_W-1:0] NUM_EXP_L = IDX_W'(NUM_EXP);
    localparam logic [IDX_W-1:0] MATCH_MAX = '1;

    mwc_state_e        state_q;
    logic [IDX_W-1:0]  matchCnt_q, matchCnt_d;
    logic [CNT_W-1:0]  cycCnt_q, cycCnt_d;
    logic              busy_q, done_q, pass_q, fail_q, timeout_q;
    logic              tableWe;
    logic [ADDR_W-1:0] expAddr;
    logic [DATA_W-1:0] expData;
    logic              addrHit, dataHit, isMatch, isMismatch, isFinal;

    assign tableWe = exp_we && (state_q == IDLE);

    mwc_exp_table #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NUM_EXP (NUM_EXP),
        .IDX_W   (IDX_W)
    ) u_table (
        .clk_i     (clk),
        .wr_en_i   (tableWe),
        .wr_idx_i  (exp_idx),
        .wr_addr_i (exp_addr),
        .wr_data_i (exp_data),
        .rd_idx_i  (matchCnt_q),
        .rd_addr_o (expAddr),
        .rd_data_o (expData)
    );

    // Sparse mode only objects to a store that hits the expected address with wrong data.
    always_comb begin
        addrHit = (data_addr == expAddr);
        dataHit = (write_data == expData);
        isMatch = mem_write && addrHit && dataHit;
        if (SPARSE == MWC_SPARSE) begin
            isMismatch = mem_write && addrHit && !dataHit;
        end else begin
            isMismatch = mem_write && !isMatch;
        end
        matchCnt_d = (matchCnt_q == MATCH_MAX) ? matchCnt_q : matchCnt_q + 1'b1;
        cycCnt_d   = (cycCnt_q == CYC_MAX) ? cycCnt_q : cycCnt_q + 1'b1;
        isFinal    = isMatch && (matchCnt_d == NUM_EXP_L);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            matchCnt_q <= '0;
            cycCnt_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RUN;
                        busy_q     <= 1'b1;
                        matchCnt_q <= '0;
                        cycCnt_q   <= '0;
                    end
                end
                RUN: begin
                    cycCnt_q <= cycCnt_d;
                    if (isMatch) begin
                        matchCnt_q <= matchCnt_d;
                    end
                    // A terminal store on the last cycle outranks the timeout.
                    if (isFinal) begin
                        state_q <= PASS;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b1;
                    end else if (isMismatch) begin
                        state_q <= FAIL;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        fail_q  <= 1'b1;
                    end else if (cycCnt_q == CYC_LAST) begin
                        state_q   <= TIMEOUT;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timeout   = timeout_q;
    assign match_cnt = matchCnt_q;

`ifdef CHECKER_DEBUG_EN
    logic [ADDR_W-1:0] failAddr_q;
    logic [DATA_W-1:0] failData_q;
    logic [IDX_W-1:0]  failIdx_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            failAddr_q <= '0;
            failData_q <= '0;
            failIdx_q  <= '0;
        end else if ((state_q == RUN) && isMismatch) begin
            failAddr_q <= data_addr;
            failData_q <= write_data;
            failIdx_q  <= matchCnt_q;
        end
    end

    assign fail_addr = failAddr_q;
    assign fail_data = failData_q;
    assign fail_idx  = failIdx_q;
`endif

endmodule
